// File: rtl/demux_regbank16.sv
// ----------------------------------------------------------------------------
// demux_regbank16
// Write side of a 16-entry register bank. A 4-bit write select is decoded into
// one-hot write enables; the addressed entry captures wr_data on the rising
// clock edge. Entry 15 is a hardwired zero register. Bank contents are
// presented bit-sliced so each 16-bit group drives one mux16_1 read slice.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous, active-high; clears all entries and wr_count
//   wr_en      : write request for this cycle
//   wr_sel     : entry index to write (0..15)
//   wr_data    : data to write (WIDTH bits)
//   dec_out    : combinational one-hot write enables (wr_en & wr_sel == i)
//   slices_out : slices_out[b*16 + i] = bit b of entry i
//   wr_count   : accepted writes since reset, saturating at 255
// ----------------------------------------------------------------------------
module demux_regbank16 #(
  parameter int WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [15:0]           dec_out,
  output logic [16*WIDTH-1:0]   slices_out,
  output logic [7:0]            wr_count
);

  // Only entries 0..14 have storage; entry 15 is constant zero.
  logic [WIDTH-1:0]    entry_r [0:14];
  logic [7:0]          count_r;
  logic [15:0]         dec_s;
  logic                accept_s;
  logic [16*WIDTH-1:0] slices_s;

  // 1:16 demux of wr_en. With wr_en low every term is 0 even if wr_sel is X.
  always_comb begin
    dec_s = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      dec_s[i] = wr_en & (wr_sel == 4'(i));
    end
  end

  // A write is accepted only when it targets a real entry; writes to the
  // zero register are dropped and not counted.
  always_comb begin
    accept_s = |dec_s[14:0];
  end

  // Entry storage: reset clears everything and wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (dec_s[i]) begin
          entry_r[i] <= wr_data;
        end else begin
          entry_r[i] <= entry_r[i];
        end
      end
    end
  end

  // Accepted-write counter, holds at 255 instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (accept_s && (count_r != 8'd255)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Bit-slice the bank: group b collects bit b of every entry, with the
  // entry-15 position tied low.
  always_comb begin
    slices_s = '0;
    for (int b = 0; b < WIDTH; b++) begin
      for (int i = 0; i < 15; i++) begin
        slices_s[b*16 + i] = entry_r[i][b];
      end
      slices_s[b*16 + 15] = 1'b0;
    end
  end

  assign dec_out    = dec_s;
  assign slices_out = slices_s;
  assign wr_count   = count_r;

endmodule

// File: tb/tb_demux_regbank16.sv
`timescale 10ps/1ps
module tb_demux_regbank16;

  localparam int W = 64;

  logic           clk;
  logic           reset;
  logic           wr_en;
  logic [3:0]     wr_sel;
  logic [W-1:0]   wr_data;
  logic [15:0]    dec_out;
  logic [16*W-1:0] slices_out;
  logic [7:0]     wr_count;

  int pass_cnt;
  int total_cnt;

  demux_regbank16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .dec_out    (dec_out),
    .slices_out (slices_out),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Reassemble entry i from the bit-sliced output.
  function automatic logic [W-1:0] get_entry(input int i);
    logic [W-1:0] e;
    e = '0;
    for (int b = 0; b < W; b++) e[b] = slices_out[b*16 + i];
    return e;
  endfunction

  function automatic logic [W-1:0] walk_val(input int i);
    logic [W-1:0] base;
    base = 64'h1111_1111_1111_1111;
    return base * 64'(i);
  endfunction

  // One rising edge, then settle at the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_sel = 4'd3; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    total_cnt++;
    if (dec_out !== 16'h0008) $display("FAIL reset_dec_pre: got %h expected %h", dec_out, 16'h0008);
    else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      step();
      total_cnt++;
      if (slices_out !== '0) $display("FAIL reset_slices c%0d: got %h expected 0", c, slices_out);
      else pass_cnt++;
      total_cnt++;
      if (wr_count !== 8'd0) $display("FAIL reset_count c%0d: got %0d expected 0", c, wr_count);
      else pass_cnt++;
      total_cnt++;
      if (dec_out !== 16'h0008) $display("FAIL reset_dec c%0d: got %h expected %h", c, dec_out, 16'h0008);
      else pass_cnt++;
    end
  endtask

  task automatic test_walk();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_sel = 4'(i); wr_data = walk_val(i);
      #1;
      total_cnt++;
      if (dec_out !== (16'h0001 << i)) $display("FAIL walk_dec %0d: got %h expected %h", i, dec_out, 16'h0001 << i);
      else pass_cnt++;
      step();
      for (int j = 0; j < 16; j++) begin
        logic [W-1:0] exp;
        exp = (j <= i && j < 15) ? walk_val(j) : 64'h0;
        total_cnt++;
        if (get_entry(j) !== exp) $display("FAIL walk_entry %0d after %0d: got %h expected %h", j, i, get_entry(j), exp);
        else pass_cnt++;
      end
      total_cnt++;
      if (wr_count !== 8'(i + 1)) $display("FAIL walk_count %0d: got %0d expected %0d", i, wr_count, i + 1);
      else pass_cnt++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_sel = 4'd15; wr_data = 64'hDEAD_BEEF_0000_0001;
    #1;
    total_cnt++;
    if (dec_out !== 16'h8000) $display("FAIL zero_dec: got %h expected %h", dec_out, 16'h8000);
    else pass_cnt++;
    step();
    wr_en = 1'b0;
    total_cnt++;
    if (get_entry(15) !== 64'h0) $display("FAIL zero_entry: got %h expected 0", get_entry(15));
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== 8'd15) $display("FAIL zero_count: got %0d expected 15", wr_count);
    else pass_cnt++;
    total_cnt++;
    if (get_entry(14) !== walk_val(14)) $display("FAIL zero_e14: got %h expected %h", get_entry(14), walk_val(14));
    else pass_cnt++;
  endtask

  task automatic test_hold_overwrite();
    wr_en = 1'b0; wr_data = 64'hFFFF_0000_FFFF_0000;
    for (int s = 0; s < 16; s++) begin
      wr_sel = 4'(s);
      #1;
      total_cnt++;
      if (dec_out !== 16'h0000) $display("FAIL hold_dec %0d: got %h expected 0", s, dec_out);
      else pass_cnt++;
      step();
    end
    wr_sel = 4'bxxxx;
    #1;
    total_cnt++;
    if (dec_out !== 16'h0000) $display("FAIL hold_dec_x: got %h expected 0", dec_out);
    else pass_cnt++;
    step();
    for (int j = 0; j < 15; j++) begin
      total_cnt++;
      if (get_entry(j) !== walk_val(j)) $display("FAIL hold_entry %0d: got %h expected %h", j, get_entry(j), walk_val(j));
      else pass_cnt++;
    end
    total_cnt++;
    if (wr_count !== 8'd15) $display("FAIL hold_count: got %0d expected 15", wr_count);
    else pass_cnt++;
    // back-to-back writes to entry 7
    wr_en = 1'b1; wr_sel = 4'd7; wr_data = 64'hA5A5_A5A5_A5A5_A5A5;
    step();
    wr_data = 64'h5A5A_5A5A_5A5A_5A5A;
    #1;
    total_cnt++;
    if (get_entry(7) !== 64'hA5A5_A5A5_A5A5_A5A5) $display("FAIL b2b_first: got %h expected a5a5a5a5a5a5a5a5", get_entry(7));
    else pass_cnt++;
    step();
    wr_en = 1'b0;
    total_cnt++;
    if (get_entry(7) !== 64'h5A5A_5A5A_5A5A_5A5A) $display("FAIL b2b_last: got %h expected 5a5a5a5a5a5a5a5a", get_entry(7));
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== 8'd17) $display("FAIL b2b_count: got %0d expected 17", wr_count);
    else pass_cnt++;
    total_cnt++;
    if (get_entry(6) !== walk_val(6)) $display("FAIL b2b_e6: got %h expected %h", get_entry(6), walk_val(6));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    wr_en = 1'b1; wr_sel = 4'd2; wr_data = 64'h1234;
    step();
    total_cnt++;
    if (get_entry(2) !== 64'h1234) $display("FAIL mid_e2_written: got %h expected 1234", get_entry(2));
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== 8'd18) $display("FAIL mid_count_pre: got %0d expected 18", wr_count);
    else pass_cnt++;
    reset = 1'b1; wr_sel = 4'd4; wr_data = 64'h9999;
    step();
    reset = 1'b0; wr_en = 1'b0;
    total_cnt++;
    if (get_entry(2) !== 64'h0) $display("FAIL mid_e2: got %h expected 0", get_entry(2));
    else pass_cnt++;
    total_cnt++;
    if (get_entry(4) !== 64'h0) $display("FAIL mid_e4: got %h expected 0", get_entry(4));
    else pass_cnt++;
    total_cnt++;
    if (slices_out !== '0) $display("FAIL mid_all: got nonzero bank expected 0");
    else pass_cnt++;
    total_cnt++;
    if (wr_count !== 8'd0) $display("FAIL mid_count: got %0d expected 0", wr_count);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    wr_en = 1'b1; wr_sel = 4'd1;
    for (int k = 1; k <= 300; k++) begin
      int exp;
      wr_data = 64'(k);
      step();
      exp = (k > 255) ? 255 : k;
      total_cnt++;
      if (wr_count !== 8'(exp)) $display("FAIL sat_count %0d: got %0d expected %0d", k, wr_count, exp);
      else pass_cnt++;
    end
    wr_en = 1'b0;
    total_cnt++;
    if (get_entry(1) !== 64'd300) $display("FAIL sat_entry: got %h expected %h", get_entry(1), 64'd300);
    else pass_cnt++;
    total_cnt++;
    if (get_entry(0) !== 64'h0) $display("FAIL sat_e0: got %h expected 0", get_entry(0));
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1; wr_en = 1'b0; wr_sel = 4'd0; wr_data = '0;
    test_reset();
    test_walk();
    test_zero_reg();
    test_hold_overwrite();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
